odd_even_req_issuer: RTL

Upstream request-issuing stage for the odd/even request/acknowledge lanes. It accepts a lane-mask command and drives a registered `req` vector in two strictly separated phases: even-indexed lanes first, then odd-indexed lanes. Each lane's request is held until that lane acknowledges, and each phase is bounded by a timeout. On completion it reports per command which lanes acknowledged and whether a timeout occurred. The odd/even checking stage sits directly downstream and consumes `req` and `ack`.

---
 rtl/odd_even_req_issuer.sv | 95 +++++++++
 1 files changed

// File: rtl/odd_even_req_issuer.sv
// odd_even_req_issuer: two-phase (even lanes, then odd lanes) request issuer with per-phase timeout
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready, in_mask    command handshake and lanes to request
//   req, ack                      registered per-lane requests, per-lane acknowledges
//   done_valid                    one-cycle completion pulse
//   done_acked, done_timeout      completion report, held until the next accept
//   spurious_ack                  sticky: an ack was seen on a lane whose req was low
module odd_even_req_issuer #(
    parameter int N       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_mask,
    output logic [N-1:0] req,
    input  logic [N-1:0] ack,
    output logic         done_valid,
    output logic [N-1:0] done_acked,
    output logic         done_timeout,
    output logic         spurious_ack
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [N-1:0] EV = {(N/2){2'b01}};
    typedef enum logic [1:0] {IDLE, EVEN, ODD, DONE} state_t;
    state_t state_q, state_d;
    logic [N-1:0] pend_q, pend_d, req_q, req_d, acked_q, acked_d, hit, pm, rem;
    logic [CW-1:0] cnt_q, cnt_d;
    logic tmo_q, tmo_d, spur_q;
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        acked_d = acked_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        rem     = '0;
        pm      = (state_q == EVEN) ? EV : ~EV;
        hit     = ack & req_q;
        case (state_q)
            IDLE: if (in_valid) begin
                pend_d  = in_mask;
                acked_d = '0;
                tmo_d   = 1'b0;
                cnt_d   = '0;
                state_d = |(in_mask & EV) ? EVEN : |(in_mask & ~EV) ? ODD : DONE;
            end
            EVEN, ODD: begin
                pend_d  = pend_q & ~hit;
                acked_d = acked_q | hit;
                rem     = pend_d & pm;
                cnt_d   = cnt_q + 1'b1;
                if (rem == '0) begin
                    cnt_d   = '0;
                    state_d = (state_q == EVEN && |(pend_d & ~EV)) ? ODD : DONE;
                end else if (cnt_q == LAST) begin
                    // deadline: acks on this edge already counted above, the rest are abandoned
                    tmo_d   = 1'b1;
                    pend_d  = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // req is registered from the next phase, so the even->odd handover happens on one edge
        req_d = (state_d == EVEN) ? (pend_d & EV) : (state_d == ODD) ? (pend_d & ~EV) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            req_q   <= '0;
            acked_q <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            acked_q <= acked_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            spur_q  <= spur_q | |(ack & ~req_q);
        end
    end
    assign in_ready     = (state_q == IDLE);
    assign req          = req_q;
    assign done_valid   = (state_q == DONE);
    assign done_acked   = acked_q;
    assign done_timeout = tmo_q;
    assign spurious_ack = spur_q;
endmodule
